// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data-filter datapath: function-select codes,
// byte width and default sample geometry.
package iotdf_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SAMPLE_W_DEF = 128;
  localparam int unsigned ROUND_N_DEF  = 8;

  typedef enum logic [2:0] {
    FN_NONE     = 3'd0,
    FN_MAX      = 3'd1,
    FN_MIN      = 3'd2,
    FN_AVG      = 3'd3,
    FN_EXTRACT  = 3'd4,
    FN_EXCLUDE  = 3'd5,
    FN_PEAK_MAX = 3'd6,
    FN_PEAK_MIN = 3'd7
  } fn_sel_e;

endpackage

// File: rtl/iot_byte_tx_if.sv
// Sample-in / byte-out bundle between the upstream source, the serializer and
// the filter core. master = environment side, slave = serializer side.
interface iot_byte_tx_if
  import iotdf_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic [2:0]          fn_cfg;
  logic                busy;
  logic                in_en;
  logic [BYTE_W-1:0]   iot_in;
  logic [2:0]          fn_sel;
  logic                round_done;

  modport master (
    output s_valid, s_data, fn_cfg, busy,
    input  s_ready, in_en, iot_in, fn_sel, round_done
  );

  modport slave (
    input  s_valid, s_data, fn_cfg, busy,
    output s_ready, in_en, iot_in, fn_sel, round_done
  );

endinterface

// File: rtl/iot_byte_tx_byte_shifter.sv
// SAMPLE_W-wide load / shift-left-by-one-byte register exposing its MSB byte.
module byte_shifter
  import iotdf_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [SAMPLE_W-1:0] data_i,
  output logic [BYTE_W-1:0]   msb_o
);

  logic [SAMPLE_W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = shift_q << BYTE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign msb_o = shift_q[SAMPLE_W-1 -: BYTE_W];

endmodule

// File: rtl/iot_byte_tx.sv
// Serializes 128-bit samples into MSB-first bytes for the filter core, holding
// fn_sel stable across each round of ROUND_N samples and pulsing round_done.
module iot_byte_tx
  import iotdf_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned ROUND_N  = ROUND_N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  iot_byte_tx_if.slave   bus
);

  localparam int unsigned NBYTES = SAMPLE_W / BYTE_W;
  localparam int unsigned BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned SCNT_W = (ROUND_N > 1) ? $clog2(ROUND_N) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [SCNT_W-1:0] LAST_SAMP = SCNT_W'(ROUND_N - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SCNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [2:0]          fn_sel_q, fn_sel_d;
  logic                round_done_q, round_done_d;
  logic                last_byte, xfer, ready, accept;
  logic [BYTE_W-1:0]   msb;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    fn_sel_d     = fn_sel_q;
    round_done_d = 1'b0;

    last_byte = (byte_cnt_q == LAST_BYTE);
    xfer      = (state_q == SEND) && !bus.busy;
    ready     = (state_q == IDLE) || (xfer && last_byte);
    accept    = bus.s_valid && ready;

    if (xfer) begin
      byte_cnt_d = byte_cnt_q + BCNT_W'(1);
      if (last_byte) begin
        state_d = IDLE;
        if (samp_cnt_q == LAST_SAMP) begin
          samp_cnt_d   = '0;
          round_done_d = 1'b1;
        end else begin
          samp_cnt_d = samp_cnt_q + SCNT_W'(1);
        end
      end
    end

    // Test the post-increment count so a back-to-back accept that opens a new
    // round at the same edge as the previous round's last byte still latches.
    if (accept) begin
      byte_cnt_d = '0;
      state_d    = SEND;
      if (samp_cnt_d == '0) begin
        fn_sel_d = bus.fn_cfg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      fn_sel_q     <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      fn_sel_q     <= fn_sel_d;
      round_done_q <= round_done_d;
    end
  end

  byte_shifter #(
    .SAMPLE_W (SAMPLE_W)
  ) u_byte_shifter (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (accept),
    .shift_i (xfer),
    .data_i  (bus.s_data),
    .msb_o   (msb)
  );

  assign bus.s_ready    = ready;
  assign bus.in_en      = xfer;
  assign bus.iot_in     = (state_q == SEND) ? msb : '0;
  assign bus.fn_sel     = fn_sel_q;
  assign bus.round_done = round_done_q;

endmodule

// File: tb/tb_iot_byte_tx.sv
// Directed bench for iot_byte_tx: single sample, stalls, full rounds with
// fn_cfg change, last-byte stall with back-to-back accept, mid-sample reset.
module tb_iot_byte_tx;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  iot_byte_tx_if #(.SAMPLE_W(128)) bus ();

  iot_byte_tx #(
    .SAMPLE_W (128),
    .ROUND_N  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bval(input int unsigned k, input int unsigned j);
    return 8'((k % 16) * 16 + j);
  endfunction

  function automatic logic [127:0] samp(input int unsigned k);
    logic [127:0] v;
    v = '0;
    for (int unsigned j = 0; j < 16; j++) v[127-8*j -: 8] = bval(k, j);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.busy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.fn_cfg = 3'd0;
    bus.busy = 1'b0;
    #2;
    chk("rst_in_en", 32'(bus.in_en), 32'd0);
    chk("rst_iot_in", 32'(bus.iot_in), 32'd0);
    chk("rst_fn_sel", 32'(bus.fn_sel), 32'd0);
    chk("rst_round_done", 32'(bus.round_done), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // single sample, no stall
    bus.fn_cfg = 3'd3;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    #1;
    chk("t1_ready_idle", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("t1_in_en", 32'(bus.in_en), 32'd1);
      chk("t1_byte", 32'(bus.iot_in), 32'(c));
      chk("t1_ready", 32'(bus.s_ready), 32'(c == 15));
      tick();
    end
    #1;
    chk("t1_end_in_en", 32'(bus.in_en), 32'd0);
    chk("t1_end_ready", 32'(bus.s_ready), 32'd1);
    chk("t1_end_iot_in", 32'(bus.iot_in), 32'd0);
    chk("t1_fn_sel", 32'(bus.fn_sel), 32'd3);
    chk("t1_round_done", 32'(bus.round_done), 32'd0);

    // busy on transfer cycles 3..5
    do_reset();
    bus.fn_cfg = 3'd3;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    for (int c = 0; c < 19; c++) begin
      bus.busy = (c >= 3 && c <= 5);
      #1;
      chk("t2_in_en", 32'(bus.in_en), 32'(!(c >= 3 && c <= 5)));
      chk("t2_byte", 32'(bus.iot_in), 32'((c < 3) ? c : ((c <= 5) ? 3 : c - 3)));
      tick();
    end
    bus.busy = 1'b0;
    #1;
    chk("t2_end_in_en", 32'(bus.in_en), 32'd0);
    chk("t2_end_ready", 32'(bus.s_ready), 32'd1);

    // nine back-to-back samples, fn_cfg 4 -> 6 mid-round
    do_reset();
    bus.fn_cfg = 3'd4;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    tick();
    for (int c = 0; c < 144; c++) begin
      bus.s_valid = (c / 16) < 8;
      bus.s_data = samp(c / 16 + 1);
      if (c == 64) bus.fn_cfg = 3'd6;
      #1;
      chk("t3_in_en", 32'(bus.in_en), 32'd1);
      chk("t3_byte", 32'(bus.iot_in), 32'(bval(c / 16, c % 16)));
      chk("t3_fn_sel", 32'(bus.fn_sel), (c < 128) ? 32'd4 : 32'd6);
      chk("t3_round_done", 32'(bus.round_done), 32'(c == 128));
      chk("t3_ready", 32'(bus.s_ready), 32'((c % 16) == 15));
      tick();
    end
    bus.s_valid = 1'b0;
    #1;
    chk("t3_end_in_en", 32'(bus.in_en), 32'd0);
    chk("t3_end_ready", 32'(bus.s_ready), 32'd1);
    chk("t3_end_fn_sel", 32'(bus.fn_sel), 32'd6);
    chk("t3_end_round_done", 32'(bus.round_done), 32'd0);

    // busy exactly on byte 15 with next sample waiting
    do_reset();
    bus.fn_cfg = 3'd2;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    tick();
    bus.s_data = samp(1);
    for (int c = 0; c < 33; c++) begin
      bus.busy = (c == 15);
      bus.s_valid = (c <= 16);
      #1;
      chk("t5_in_en", 32'(bus.in_en), 32'(c != 15));
      chk("t5_byte", 32'(bus.iot_in),
          (c <= 15) ? 32'(c) : ((c == 16) ? 32'd15 : 32'(bval(1, c - 17))));
      chk("t5_ready", 32'(bus.s_ready), 32'(c == 16 || c == 32));
      tick();
    end
    bus.busy = 1'b0;
    #1;
    chk("t5_end_in_en", 32'(bus.in_en), 32'd0);
    chk("t5_fn_sel", 32'(bus.fn_sel), 32'd2);

    // asynchronous reset during byte 7 of sample 3
    do_reset();
    bus.fn_cfg = 3'd5;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    tick();
    for (int c = 0; c < 39; c++) begin
      bus.s_data = samp(c / 16 + 1);
      #1;
      chk("t6_pre_byte", 32'(bus.iot_in), 32'(bval(c / 16, c % 16)));
      chk("t6_pre_fn_sel", 32'(bus.fn_sel), 32'd5);
      tick();
    end
    rst = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("t6_rst_in_en", 32'(bus.in_en), 32'd0);
    chk("t6_rst_iot_in", 32'(bus.iot_in), 32'd0);
    chk("t6_rst_fn_sel", 32'(bus.fn_sel), 32'd0);
    chk("t6_rst_round_done", 32'(bus.round_done), 32'd0);
    chk("t6_rst_ready", 32'(bus.s_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    bus.fn_cfg = 3'd1;
    bus.s_data = samp(0);
    bus.s_valid = 1'b1;
    tick();
    for (int c = 0; c < 129; c++) begin
      bus.s_valid = (c / 16) < 7;
      bus.s_data = samp(c / 16 + 1);
      #1;
      if (c < 128) begin
        chk("t6_in_en", 32'(bus.in_en), 32'd1);
        chk("t6_byte", 32'(bus.iot_in), 32'(bval(c / 16, c % 16)));
      end
      chk("t6_round_done", 32'(bus.round_done), 32'(c == 128));
      chk("t6_fn_sel", 32'(bus.fn_sel), 32'd1);
      tick();
    end
    #1;
    chk("t6_end_in_en", 32'(bus.in_en), 32'd0);
    chk("t6_end_round_done", 32'(bus.round_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iot_byte_tx.md
# iot_byte_tx

Sample serializer that drives the IoT data-filter core's input side. It accepts whole 128-bit samples from an upstream source over a valid/ready handshake. It emits each sample as 16 bytes, MSB byte first, on `iot_in`/`in_en`, and stalls whenever the filter core raises `busy`. It also fixes the function select for each round of samples and flags round completion, so the filter core and its output selector see a stable `fn_sel` for the whole round.

## Interface

Parameters:

- `SAMPLE_W`, default 128: sample width in bits; must be a multiple of 8.
- `ROUND_N`, default 8: samples per round.

Ports:

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: upstream sample valid.
- `s_ready`, out, 1: block can accept a sample.
- `s_data`, in, SAMPLE_W: upstream sample.
- `fn_cfg`, in, 3: requested function for the next round.
- `busy`, in, 1: filter core cannot take a byte this cycle.
- `in_en`, out, 1: byte on `iot_in` is transferred this cycle.
- `iot_in`, out, 8: current byte.
- `fn_sel`, out, 3: function select held for the active round.
- `round_done`, out, 1: one-cycle pulse after the last byte of the round's last sample.

## Operation

- States are IDLE and SEND. `rst` low forces IDLE and clears the shift register, byte counter, sample counter, `fn_sel` and `round_done`.
- Reset values: `in_en`=0, `iot_in`=0, `fn_sel`=0, `round_done`=0, `s_ready`=1.
- `s_ready` is combinational: it is 1 in IDLE, and 1 in SEND only on the last byte (byte index 15) when `busy`=0. A handshake asserted while `rst` is low is ignored.
- Accept occurs on `s_valid & s_ready` at an edge:
  - load `s_data` into the shift register;
  - clear the byte counter;
  - enter or stay in SEND.
  - If the sample counter is 0, also capture `fn_cfg` into `fn_sel`. Otherwise `fn_sel` is unchanged.
- In SEND, `iot_in` is `shift[SAMPLE_W-1 -: 8]` and `in_en` = ~`busy`, combinational from the registered state.
- Transfer occurs on `in_en`=1 at an edge: shift left by 8 and increment the byte counter.
- With `busy`=1, `in_en`=0 and the shift register, counter and `iot_in` all hold.
- Last-byte transfer (index `SAMPLE_W/8-1`):
  - increment the sample counter, wrapping at `ROUND_N` to 0;
  - on wrap, pulse `round_done` on the next cycle;
  - if a new sample is accepted at the same edge, stay in SEND with the new data; otherwise go to IDLE.
- Back-to-back samples therefore need no idle cycle: byte 0 of sample k+1 follows byte 15 of sample k directly.
- `fn_cfg` changes in mid-round have no effect until the next round's first accept.
- `busy` rising on the last byte holds the byte, and `s_ready` is deasserted for that cycle.

## Timing

- Latency: the accept edge puts byte 0 on `iot_in` the following cycle, with `in_en` high if `busy`=0.
- With no stalls, a sample takes exactly `SAMPLE_W/8` cycles of `in_en`=1.
- Stalls add one cycle per `busy`-high cycle; there is no byte loss and no duplication.
- `round_done` is registered and asserts the cycle after the final transfer edge of sample `ROUND_N`.
- `fn_sel` changes only at the accept edge of a round's first sample.
- Asynchronous reset in mid-sample:
  - the in-flight sample is discarded and the round counter restarts at 0;
  - outputs take their reset values immediately, not waiting for a clock edge.

## Structure

- Shared package `iotdf_pkg` holds:
  - the function-select constants: F1 max, F2 min, F3 avg, F4 extract, F5 exclude, F6 peak-max, F7 peak-min, as 3-bit encodings 1..7;
  - `BYTE_W`=8;
  - the default `SAMPLE_W`/`ROUND_N`.
- The state enum (IDLE, SEND) is local.
- One sub-module is natural: `byte_shifter`, a SAMPLE_W load/shift-by-8 register exposing the MSB byte.
- Counters and the FSM stay in the top.

## Test plan

- Reset, then accept one sample 0x000102…0F with `busy`=0:
  - `iot_in` reads 0x00,0x01,…,0x0F on 16 consecutive cycles with `in_en`=1;
  - the block returns to IDLE with `s_ready`=1.
- Same sample with `busy` high on cycles 3–5 of the transfer:
  - `in_en`=0 for those 3 cycles and byte 0x03 is held;
  - 19 cycles total; the byte sequence is unchanged.
- `s_valid` held high with 8 distinct samples and `fn_cfg`=4:
  - 128 consecutive transfers with no gap;
  - `fn_sel`=4 throughout;
  - `round_done` pulses once, 1 cycle after the 128th transfer.
- `fn_cfg` switched from 4 to 6 mid-round:
  - `fn_sel` stays 4 until the 9th sample's accept edge, then becomes 6.
- `busy` asserted exactly on byte 15 while `s_valid`=1:
  - `s_ready`=0 during the stall;
  - the next sample is accepted on the first non-busy cycle and byte 15 is transferred once.
- `rst` pulled low during byte 7 of sample 3:
  - `in_en`, `iot_in`, `fn_sel` and `round_done` drop to 0 asynchronously;
  - after release, a full round is needed again before `round_done` pulses.
